butterfly_r2_pipe: RTL
======================

# butterfly_r2_pipe

Parametrised, pipelined radix-2 DIF butterfly for the FFT datapath. It computes X = A + B and Y = (A − B)·W with a per-sample runtime twiddle, and supports forward/inverse mode, optional per-stage scaling, and rounding with saturation. A valid/ready handshake carries backpressure, so FFT stages chain without external stall logic. Throughput is one butterfly per cycle.

## Interface
- DATA_W, 16: signed width of each real/imag data component (in and out).
- TW_W, 16: signed twiddle component width, format Q1.(TW_W−1).
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts input this cycle.
- in_a_r, in_a_i, in_b_r, in_b_i  in  DATA_W each  operands A and B.
- in_w_r, in_w_i  in  TW_W each  twiddle W for this sample.
- in_bypass  in  1  twiddle multiply skipped (W = 1, e.g. k = 0).
- cfg_scale  in  1  halve X and Y (≈>>1) in this stage.
- cfg_inverse  in  1  use conj(W).
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts output.
- out_x_r, out_x_i, out_y_r, out_y_i  out  DATA_W each  results.
- sat_flag  out  1  sticky: any saturation since reset/clear.
- sat_clear  in  1  clears sat_flag.

## Operation
- Transfer occurs when valid && ready on the same edge.
- in_bypass, cfg_scale and cfg_inverse are captured with the sample and travel with it. Mode changes apply per sample.
- Pipeline stages:
  - S1: s = A + B, d = A − B, both DATA_W+1 bits. If scale = 1, each becomes (v + 1) >>> 1. Otherwise each saturates to DATA_W.
  - S2: form the four products d·W, each DATA_W+TW_W bits. If inverse = 1, replace w_i with −w_i. Negating −2^(TW_W−1) saturates to 2^(TW_W−1)−1.
  - S3: compute y_r = d_r·w_r − d_i·w_i and y_i = d_r·w_i + d_i·w_r, each DATA_W+TW_W+1 bits. Add 2^(TW_W−2), shift >>> (TW_W−1), then saturate to DATA_W. If bypass = 1, Y = d unchanged. X = s, delayed to align with Y.
- Saturation clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Any clamp on an accepted sample sets sat_flag at the edge that clamp value enters a stage register. If set and sat_clear coincide, set wins.
- No sample is dropped, duplicated or reordered.

## Timing
- Latency: 3 cycles from input acceptance to out_valid, when out_ready stays high.
- Each stage register has a valid bit. Stage k loads when it is empty or stage k+1 loads (bubbles collapse).
  - in_ready = !v1 || load2.
  - out_valid = v3.
  - in_ready is combinational from out_ready through the valid chain. The depth is 3, so this is acceptable.
- With out_ready low, the block holds at most 3 samples. in_ready drops once all 3 stages are full.
- out_* are stable while out_valid && !out_ready.
- Reset (reset_n low) asynchronously clears:
  - all stage valid bits (out_valid = 0),
  - all data registers and out_* (to 0),
  - sat_flag (to 0).
- in_ready is 1 in the first cycle after reset_n deasserts.
- Reset mid-stream discards all in-flight samples.

## Structure
- The shared FFT package holds:
  - default DATA_W/TW_W constants,
  - a saturate function (width-generic via a parameterised class or a macro),
  - the twiddle Q-format constants: TW_ONE_NEG = −2^(TW_W−1) and TW_MAX.
- One sub-module, bf_pipe_stage: a valid/ready register slice with load enable and async reset, parameterised by payload width. It is instantiated three times.
- Arithmetic stays in butterfly_r2_pipe.

## Test plan
All cases use DATA_W = TW_W = 16.
- **Bypass:** A = (100, 50), B = (20, −10), bypass = 1, scale = 0 → 3 cycles later X = (120, 40), Y = (80, 60), sat_flag = 0.
- **Twiddle and inverse:** same A/B, W = (0, −32768), bypass = 0 → Y = (60, −80). With cfg_inverse = 1 (W_i saturates to +32767) → Y = (−60, 80).
- **Saturation and scaling:**
  - A = B = (32767, 0), scale = 0 → X = (32767, 0), sat_flag = 1.
  - sat_clear pulse → 0.
  - Same input with scale = 1 → X = (32767, 0), sat_flag stays 0.
- **Backpressure:** stream 10 distinct samples back-to-back, out_ready low for cycles 4–8.
  - in_ready drops with 3 samples held.
  - All 10 outputs appear in order, none lost or duplicated.
  - Outputs stay stable while stalled.
- **Throughput:** 16 samples, out_ready = 1 → out_valid high 16 consecutive cycles starting 3 cycles after the first accept.
- **Async reset:** drop reset_n mid-stall, between clock edges → out_valid, out_* and sat_flag go to 0 immediately. After release, in_ready = 1 and the next sample emerges alone.

Source files
------------

// File: rtl/butterfly_r2_pipe_pkg.sv
// Shared FFT datapath package: default widths, twiddle Q-format constants
// and a width-generic saturation helper.
package butterfly_r2_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TW_W_DEF   = 16;
  localparam int SAT_W      = 64;

  localparam logic signed [TW_W_DEF-1:0] TW_ONE_NEG = {1'b1, {(TW_W_DEF-1){1'b0}}};
  localparam logic signed [TW_W_DEF-1:0] TW_MAX     = {1'b0, {(TW_W_DEF-1){1'b1}}};

  // Clamp a wide signed value into the range of a w-bit signed number
  function automatic logic signed [SAT_W-1:0] sat_val(input logic signed [SAT_W-1:0] v,
                                                      input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_val = hi;
    end else if (v < lo) begin
      sat_val = lo;
    end else begin
      sat_val = v;
    end
  endfunction

  function automatic logic sat_hit(input logic signed [SAT_W-1:0] v, input int w);
    return sat_val(v, w) != v;
  endfunction

endpackage

// File: rtl/bf_pipe_stage.sv
// Valid/ready register slice: one payload register plus its valid bit,
// loaded whenever the pipeline control says this stage may advance.
module bf_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Stage register; payload only moves for real samples so bubbles cost no toggles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end else begin
        r_data <= r_data;
      end
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Three-stage radix-2 DIF butterfly: X = A + B, Y = (A - B) * W, with
// per-sample bypass/scale/inverse and collapsing valid/ready backpressure.
module butterfly_r2_pipe
  import butterfly_r2_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a_r,
  input  logic signed [DATA_W-1:0] in_a_i,
  input  logic signed [DATA_W-1:0] in_b_r,
  input  logic signed [DATA_W-1:0] in_b_i,
  input  logic signed [TW_W-1:0]   in_w_r,
  input  logic signed [TW_W-1:0]   in_w_i,
  input  logic                     in_bypass,
  input  logic                     cfg_scale,
  input  logic                     cfg_inverse,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x_r,
  output logic signed [DATA_W-1:0] out_x_i,
  output logic signed [DATA_W-1:0] out_y_r,
  output logic signed [DATA_W-1:0] out_y_i,
  output logic                     sat_flag,
  input  logic                     sat_clear
);

  localparam int PW = DATA_W + TW_W;
  localparam logic signed [PW:0] RND = (PW+1)'(64'sd1 <<< (TW_W - 2));

  typedef struct packed {
    logic signed [DATA_W-1:0] s_r;
    logic signed [DATA_W-1:0] s_i;
    logic signed [DATA_W-1:0] d_r;
    logic signed [DATA_W-1:0] d_i;
    logic signed [TW_W-1:0]   w_r;
    logic signed [TW_W-1:0]   w_i;
    logic                     byp;
    logic                     inv;
  } s1_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] s_r;
    logic signed [DATA_W-1:0] s_i;
    logic signed [DATA_W-1:0] d_r;
    logic signed [DATA_W-1:0] d_i;
    logic signed [PW-1:0]     p_rr;
    logic signed [PW-1:0]     p_ii;
    logic signed [PW-1:0]     p_ri;
    logic signed [PW-1:0]     p_ir;
    logic                     byp;
  } s2_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] x_r;
    logic signed [DATA_W-1:0] x_i;
    logic signed [DATA_W-1:0] y_r;
    logic signed [DATA_W-1:0] y_i;
  } s3_t;

  // Halve with round-half-up, or clamp the one-bit-wider sum back to DATA_W
  function automatic logic signed [DATA_W-1:0] s1_fix(input logic signed [DATA_W:0] v,
                                                      input logic sc);
    logic signed [DATA_W+1:0] t;
    logic signed [SAT_W-1:0]  q;
    if (sc) begin
      t = (DATA_W+2)'(v) + (DATA_W+2)'(2'sb01);
      q = SAT_W'(t >>> 1);
    end else begin
      t = '0;
      q = sat_val(SAT_W'(v), DATA_W);
    end
    return DATA_W'(q);
  endfunction

  s1_t w_s1_d, w_r1;
  s2_t w_s2_d, w_r2;
  s3_t w_s3_d, w_r3;
  logic w_v1, w_v2, w_v3;
  logic w_ld1, w_ld2, w_ld3;
  logic w_hit1, w_hit2, w_hit3;
  logic r_sat_flag;

  logic signed [DATA_W:0]  w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic signed [SAT_W-1:0] w_wi_neg;
  logic signed [TW_W-1:0]  w_wi_eff;
  logic signed [PW:0]      w_yr_full, w_yi_full, w_yr_q, w_yi_q;

  // Stage 1 input: sum and difference, then scale or saturate
  always_comb begin
    w_s1_d  = '0;
    w_sum_r = (DATA_W+1)'(in_a_r) + (DATA_W+1)'(in_b_r);
    w_sum_i = (DATA_W+1)'(in_a_i) + (DATA_W+1)'(in_b_i);
    w_dif_r = (DATA_W+1)'(in_a_r) - (DATA_W+1)'(in_b_r);
    w_dif_i = (DATA_W+1)'(in_a_i) - (DATA_W+1)'(in_b_i);
    w_s1_d.s_r = s1_fix(w_sum_r, cfg_scale);
    w_s1_d.s_i = s1_fix(w_sum_i, cfg_scale);
    w_s1_d.d_r = s1_fix(w_dif_r, cfg_scale);
    w_s1_d.d_i = s1_fix(w_dif_i, cfg_scale);
    w_s1_d.w_r = in_w_r;
    w_s1_d.w_i = in_w_i;
    w_s1_d.byp = in_bypass;
    w_s1_d.inv = cfg_inverse;
    w_hit1 = !cfg_scale && (sat_hit(SAT_W'(w_sum_r), DATA_W) || sat_hit(SAT_W'(w_sum_i), DATA_W) ||
                            sat_hit(SAT_W'(w_dif_r), DATA_W) || sat_hit(SAT_W'(w_dif_i), DATA_W));
  end

  // Stage 2 input: conjugate twiddle if inverse, then the four partial products
  always_comb begin
    w_s2_d   = '0;
    w_wi_neg = -SAT_W'(w_r1.w_i);
    if (w_r1.inv) begin
      w_wi_eff = TW_W'(sat_val(w_wi_neg, TW_W));
      w_hit2   = !w_r1.byp && sat_hit(w_wi_neg, TW_W);
    end else begin
      w_wi_eff = w_r1.w_i;
      w_hit2   = 1'b0;
    end
    w_s2_d.s_r  = w_r1.s_r;
    w_s2_d.s_i  = w_r1.s_i;
    w_s2_d.d_r  = w_r1.d_r;
    w_s2_d.d_i  = w_r1.d_i;
    w_s2_d.p_rr = PW'(w_r1.d_r) * PW'(w_r1.w_r);
    w_s2_d.p_ii = PW'(w_r1.d_i) * PW'(w_wi_eff);
    w_s2_d.p_ri = PW'(w_r1.d_r) * PW'(w_wi_eff);
    w_s2_d.p_ir = PW'(w_r1.d_i) * PW'(w_r1.w_r);
    w_s2_d.byp  = w_r1.byp;
  end

  // Stage 3 input: combine products, round to nearest, drop Q-format bits, clamp
  always_comb begin
    w_s3_d    = '0;
    w_yr_full = (PW+1)'(w_r2.p_rr) - (PW+1)'(w_r2.p_ii) + RND;
    w_yi_full = (PW+1)'(w_r2.p_ri) + (PW+1)'(w_r2.p_ir) + RND;
    w_yr_q    = w_yr_full >>> (TW_W - 1);
    w_yi_q    = w_yi_full >>> (TW_W - 1);
    w_s3_d.x_r = w_r2.s_r;
    w_s3_d.x_i = w_r2.s_i;
    if (w_r2.byp) begin
      w_s3_d.y_r = w_r2.d_r;
      w_s3_d.y_i = w_r2.d_i;
      w_hit3     = 1'b0;
    end else begin
      w_s3_d.y_r = DATA_W'(sat_val(SAT_W'(w_yr_q), DATA_W));
      w_s3_d.y_i = DATA_W'(sat_val(SAT_W'(w_yi_q), DATA_W));
      w_hit3     = sat_hit(SAT_W'(w_yr_q), DATA_W) || sat_hit(SAT_W'(w_yi_q), DATA_W);
    end
  end

  // A stage advances when empty or when the next one advances
  assign w_ld3    = !w_v3 || out_ready;
  assign w_ld2    = !w_v2 || w_ld3;
  assign w_ld1    = !w_v1 || w_ld2;
  assign in_ready = w_ld1;

  bf_pipe_stage #(.W($bits(s1_t))) u_st1 (
    .clk(clk), .reset_n(reset_n), .i_load(w_ld1), .i_valid(in_valid),
    .i_data(w_s1_d), .o_valid(w_v1), .o_data(w_r1)
  );

  bf_pipe_stage #(.W($bits(s2_t))) u_st2 (
    .clk(clk), .reset_n(reset_n), .i_load(w_ld2), .i_valid(w_v1),
    .i_data(w_s2_d), .o_valid(w_v2), .o_data(w_r2)
  );

  bf_pipe_stage #(.W($bits(s3_t))) u_st3 (
    .clk(clk), .reset_n(reset_n), .i_load(w_ld3), .i_valid(w_v2),
    .i_data(w_s3_d), .o_valid(w_v3), .o_data(w_r3)
  );

  // Sticky saturation flag; a clamp landing in a stage beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_flag <= 1'b0;
    end else if ((w_ld1 && in_valid && w_hit1) || (w_ld2 && w_v1 && w_hit2) ||
                 (w_ld3 && w_v2 && w_hit3)) begin
      r_sat_flag <= 1'b1;
    end else if (sat_clear) begin
      r_sat_flag <= 1'b0;
    end else begin
      r_sat_flag <= r_sat_flag;
    end
  end

  assign out_valid = w_v3;
  assign out_x_r   = w_r3.x_r;
  assign out_x_i   = w_r3.x_i;
  assign out_y_r   = w_r3.y_r;
  assign out_y_i   = w_r3.y_i;
  assign sat_flag  = r_sat_flag;

endmodule
